rand_range_sampler: RTL and testbench
=====================================

# rand_range_sampler

Downstream consumer of the LFSR random-number stage: on each 1 s sample tick it captures the (N+1)-bit random word, rejects values outside the configured range, and queues accepted values in a small FIFO. Accepted values are presented on a valid/ready port for the display or game logic. Rejection sampling gives a uniform distribution over 0..LIMIT-1 without modulo bias. It sits between the random generator (clocked by the tick pulse) and the LED/HEX driver, all in the CLOCK_50 domain.

## Interface
- N, default 3: random word is N+1 bits wide (matches the generator's q[N:0]).
- LIMIT, default 10: values < LIMIT are accepted; legal range 1..2^(N+1).
- DEPTH, default 4: FIFO entries; power of two, ≥2.
- clk  input  1  system clock (CLOCK_50 domain); single clock for the whole block.
- reset  input  1  asynchronous, active-low (0 = reset asserted); all state cleared immediately, release synchronous to clk.
- sample_tick  input  1  one-cycle strobe from the tick generator; each high cycle is one sample.
- rand_in  input  N+1  random word from the generator; sampled only when sample_tick=1.
- out_data  output  N+1  head-of-FIFO value; valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid&out_ready.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: an accepted sample was dropped because FIFO was full.

## Operation
- Accept condition: sample_tick=1 and rand_in < LIMIT (unsigned compare, N+1 bits). Rejected samples leave all state unchanged.
- Push: accepted sample written at write pointer when not full, or when full with a simultaneous pop.
- Pop: out_valid&out_ready; read pointer advances.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH; occupancy kept as a separate counter (count).
- Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - EMPTY: push -> PARTIAL (or FULL if DEPTH=1, not legal); pop ignored (out_valid=0).
  - PARTIAL: push only -> count+1; pop only -> count-1; both -> count unchanged.
  - FULL: push without pop -> sample dropped, overflow set; push with pop -> both happen, stays FULL.
- overflow cleared only by reset.
- out_ready while out_valid=0 has no effect.
- LIMIT = 2^(N+1): every sample accepted (compare constant-true).

## Timing
- Reset values: out_valid=0, count=0, overflow=0, out_data=0, pointers=0.
- Push latency: sample on tick at edge k is visible at out_data with out_valid=1 after edge k+1 (registered; no tick-to-output combinational path).
- Pop: head advances at the edge where out_valid&out_ready; next entry (or out_valid=0) visible immediately after that edge.
- Push into EMPTY with simultaneous out_ready=1: no bypass; value appears next cycle.
- Full throughput: one push and one pop per cycle sustained.
- Reset asserted mid-operation: FIFO contents discarded, outputs return to reset values asynchronously.

## Configuration
- RAND_SAMPLER_STATS_EN defined: adds outputs accept_cnt[15:0] and reject_cnt[15:0], incremented on each accepted / rejected sample_tick respectively, saturating at 16'hFFFF, reset to 0. Dropped-on-full samples still count as accepted.
- Not defined: ports and counters absent; core behaviour identical.

## Structure
- Shared package rand_pkg: clog2 function, default N/LIMIT/DEPTH constants, stats counter width (16).
- One sub-module: rand_sample_fifo (storage array, pointers, count, full/empty); top holds the range comparator, overflow flag and optional stats.

## Test plan
(N=3, LIMIT=10, DEPTH=4)
- Reset: hold reset=0 with ticks of rand_in=3 -> out_valid=0, count=0, overflow=0 throughout.
- Filter: ticks with rand_in=3,12,9,10,0, out_ready=0 -> FIFO holds 3,9,0, count=3; with STATS_EN accept_cnt=3, reject_cnt=2.
- Order/latency: tick rand_in=5 into empty FIFO -> out_valid=1, out_data=5 one cycle later; out_ready=1 -> out_valid=0 next cycle.
- Overflow: 5 accepted ticks (1,2,3,4,5), out_ready=0 -> count=4, overflow=1, drained sequence 1,2,3,4.
- Full with simultaneous push/pop: FIFO full (1,2,3,4), tick rand_in=7 with out_ready=1 -> count stays 4, overflow stays 0, drained sequence 2,3,4,7.
- Async reset mid-stream: reset=0 between clock edges with count=2 -> out_valid and count go 0 before next edge; post-release tick rand_in=8 -> out_data=8.

Source files
------------

// File: rtl/rand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rand_pkg
// Description : Shared constants and the clog2 helper for the rand range
//               sampler and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package rand_pkg;

    localparam int c_def_n     = 3;
    localparam int c_def_limit = 10;
    localparam int c_def_depth = 4;
    localparam int c_stats_w   = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rand_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rand_sample_fifo
// Description : Small power-of-two FIFO with wrapping pointers, an occupancy
//               counter and full/empty flags; async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_sample_fifo
    import rand_pkg::*;
#(
    parameter int WIDTH = c_def_n + 1,
    parameter int DEPTH = c_def_depth
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_req,
    input  logic                    pop_req,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    push_done
);

    localparam int              c_aw    = clog2(DEPTH);
    localparam int              c_cw    = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_one   = c_cw'(1);
    localparam logic [c_aw-1:0] c_pinc  = c_aw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign w_pop     = pop_req & ~empty;
    // A full FIFO still takes a push when the same edge frees a slot.
    assign w_push    = push_req & (~full | w_pop);
    assign push_done = w_push;
    assign count     = r_count;
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_pinc;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_pinc;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rand_range_sampler
// Description : Rejection-samples LFSR words into 0..LIMIT-1 and queues them
//               on a valid/ready port. Optional RAND_SAMPLER_STATS_EN adds
//               saturating accept/reject counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int N     = c_def_n,
    parameter int LIMIT = c_def_limit,
    parameter int DEPTH = c_def_depth
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic [N:0]              rand_in,
    output logic [N:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [clog2(DEPTH):0]   count,
`ifdef RAND_SAMPLER_STATS_EN
    output logic [c_stats_w-1:0]    accept_cnt,
    output logic [c_stats_w-1:0]    reject_cnt,
`endif
    output logic                    overflow
);

    // One extra bit so LIMIT = 2^(N+1) is representable and always true.
    localparam logic [N+1:0] c_limit = (N+2)'(LIMIT);

    logic w_accept;
    logic w_push_done;
    logic w_full;
    logic w_empty;
    logic r_overflow;

    assign w_accept  = sample_tick & ({1'b0, rand_in} < c_limit);
    assign out_valid = ~w_empty;
    assign overflow  = r_overflow;

    rand_sample_fifo #(
        .WIDTH (N + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_req  (w_accept),
        .pop_req   (out_ready),
        .wr_data   (rand_in),
        .rd_data   (out_data),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty),
        .push_done (w_push_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_accept & w_full & ~w_push_done) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef RAND_SAMPLER_STATS_EN
    localparam logic [c_stats_w-1:0] c_stat_one = c_stats_w'(1);

    logic [c_stats_w-1:0] r_accept_cnt;
    logic [c_stats_w-1:0] r_reject_cnt;

    assign accept_cnt = r_accept_cnt;
    assign reject_cnt = r_reject_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_accept_cnt <= '0;
            r_reject_cnt <= '0;
        end else begin
            if (w_accept && r_accept_cnt != '1)
                r_accept_cnt <= r_accept_cnt + c_stat_one;
            if (sample_tick && !w_accept && r_reject_cnt != '1)
                r_reject_cnt <= r_reject_cnt + c_stat_one;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_range_sampler
// Description : Directed self-checking bench for rand_range_sampler
//               (N=3, LIMIT=10, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_range_sampler;

    localparam int N     = 3;
    localparam int LIMIT = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_tick = 1'b0;
    logic [N:0] rand_in = '0;
    logic [N:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic       overflow;
`ifdef RAND_SAMPLER_STATS_EN
    logic [15:0] accept_cnt;
    logic [15:0] reject_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rand_range_sampler #(
        .N     (N),
        .LIMIT (LIMIT),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rand_in     (rand_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
`ifdef RAND_SAMPLER_STATS_EN
        .accept_cnt  (accept_cnt),
        .reject_cnt  (reject_cnt),
`endif
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are observed 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [N:0] v);
        sample_tick = 1'b1;
        rand_in     = v;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [N:0] v);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(v));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset held while ticks arrive
        sample_tick = 1'b1;
        rand_in     = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid",    32'(out_valid), 32'd0);
            check("rst_count",    32'(count),     32'd0);
            check("rst_overflow", 32'(overflow),  32'd0);
            check("rst_data",     32'(out_data),  32'd0);
        end
        sample_tick = 1'b0;
        reset = 1'b1;
        step();

        // Range filter: 3,12,9,10,0 -> 3,9,0 kept
        tick(4'd3); tick(4'd12); tick(4'd9); tick(4'd10); tick(4'd0);
        check("filt_count", 32'(count), 32'd3);
`ifdef RAND_SAMPLER_STATS_EN
        check("filt_acc", 32'(accept_cnt), 32'd3);
        check("filt_rej", 32'(reject_cnt), 32'd2);
`endif
        pop_expect("filt0", 4'd3);
        pop_expect("filt1", 4'd9);
        pop_expect("filt2", 4'd0);
        check("filt_empty", 32'(out_valid), 32'd0);
        check("filt_cnt0",  32'(count),     32'd0);

        // Latency into empty FIFO with ready already high: no bypass
        sample_tick = 1'b1;
        rand_in     = 4'd5;
        out_ready   = 1'b1;
        #1;
        check("lat_nocomb", 32'(out_valid), 32'd0);
        step();
        sample_tick = 1'b0;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data",  32'(out_data),  32'd5);
        check("lat_count", 32'(count),     32'd1);
        step();
        out_ready = 1'b0;
        check("lat_popped", 32'(out_valid), 32'd0);

        // Overflow: fifth accepted sample dropped
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd4);
        check("ovf_pre", 32'(overflow), 32'd0);
        tick(4'd5);
        check("ovf_count", 32'(count),    32'd4);
        check("ovf_flag",  32'(overflow), 32'd1);
        pop_expect("ovf0", 4'd1);
        pop_expect("ovf1", 4'd2);
        pop_expect("ovf2", 4'd3);
        pop_expect("ovf3", 4'd4);
        check("ovf_empty",  32'(out_valid), 32'd0);
        check("ovf_sticky", 32'(overflow),  32'd1);

        // Clear sticky flag with a reset pulse
        reset = 1'b0;
        #2;
        check("clr_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        step();

        // Full with simultaneous push and pop
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd4);
        check("fpp_full", 32'(count), 32'd4);
        check("fpp_head", 32'(out_data), 32'd1);
        out_ready = 1'b1;
        tick(4'd7);
        out_ready = 1'b0;
        check("fpp_count",    32'(count),    32'd4);
        check("fpp_overflow", 32'(overflow), 32'd0);
        pop_expect("fpp0", 4'd2);
        pop_expect("fpp1", 4'd3);
        pop_expect("fpp2", 4'd4);
        pop_expect("fpp3", 4'd7);
        check("fpp_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges
        tick(4'd1); tick(4'd2);
        check("ar_count2", 32'(count), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_count", 32'(count),     32'd0);
        check("ar_data",  32'(out_data),  32'd0);
        step();
        reset = 1'b1;
        step();
        tick(4'd8);
        check("ar_post_valid", 32'(out_valid), 32'd1);
        check("ar_post_data",  32'(out_data),  32'd8);
        check("ar_post_count", 32'(count),     32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
